fe_sweep_sequencer: RTL and testbench

//  Parametrised successor to the static front-end switch/filter register. Steps the RF

---
 rtl/fe_sweep_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fe_sweep_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_sweep_sequencer.sv
// RF front-end sweep sequencer: steps fe_ctrl through a programmable table, blanking rx
// samples while each setting settles, then passing a fixed count of strobes per step.
module fe_sweep_sequencer #(
  parameter int         NUM_STEPS    = 8,
  parameter int         CTRL_WIDTH   = 6,
  parameter int         DWELL_WIDTH  = 16,
  parameter int         SETTLE_WIDTH = 12,
  parameter logic [6:0] BASEADDR     = 7'd80,
  localparam int        IW           = $clog2(NUM_STEPS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            serial_addr,
  input  logic [31:0]           serial_data,
  input  logic                  serial_strobe,
  input  logic                  sample_strobe,
  output logic [CTRL_WIDTH-1:0] fe_ctrl,
  output logic [IW-1:0]         step_index,
  output logic                  sample_valid,
  output logic                  step_start,
  output logic                  sweep_done,
  output logic                  busy,
  output logic [1:0]            dbg_state,
  output logic                  dbg_enable
);

  // Handshakes: serial_strobe and sample_strobe are single-cycle qualifiers with no
  // back-pressure; every high cycle is exactly one write / one sample and is always taken.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  localparam logic [7:0] BASE8  = {1'b0, BASEADDR};
  localparam logic [7:0] TAB_LO = BASE8 + 8'd2;
  localparam logic [7:0] TAB_HI = TAB_LO + 8'(NUM_STEPS);

  state_t state, state_next;

  logic                    enable;
  logic                    one_shot;
  logic [3:0]              last_raw;
  logic [SETTLE_WIDTH-1:0] settle_reg;
  logic [CTRL_WIDTH-1:0]   ctrl_tab  [NUM_STEPS];
  logic [DWELL_WIDTH-1:0]  dwell_tab [NUM_STEPS];

  logic [SETTLE_WIDTH-1:0] settle_cnt;
  logic [DWELL_WIDTH-1:0]  dwell_rem;

  logic [7:0]  addr8;
  logic [7:0]  tab_off;
  logic [IW-1:0] tab_idx;
  logic        wr_ctrl, wr_settle, wr_tab, abort;
  logic        os_eff;
  logic [3:0]  ls_src;
  logic [IW-1:0] ls_eff;
  logic [SETTLE_WIDTH-1:0] settle_eff;
  logic        dwell_end;
  logic        load, done;
  logic [IW-1:0] load_idx;
  logic [CTRL_WIDTH-1:0]  ld_ctrl;
  logic [DWELL_WIDTH-1:0] ld_dwell;
  logic        pass_sample;
  logic        unused_bits;

  // Register decode
  assign addr8     = {1'b0, serial_addr};
  assign tab_off   = addr8 - TAB_LO;
  assign tab_idx   = tab_off[IW-1:0];
  assign wr_ctrl   = serial_strobe && (serial_addr == BASEADDR);
  assign wr_settle = serial_strobe && (addr8 == BASE8 + 8'd1);
  assign wr_tab    = serial_strobe && (addr8 >= TAB_LO) && (addr8 < TAB_HI);
  assign abort     = wr_ctrl && !serial_data[0];
  assign unused_bits = ^{serial_data, tab_off};

  // A write landing on the same cycle as a decision is seen by that decision.
  assign os_eff     = wr_ctrl ? serial_data[1] : one_shot;
  assign ls_src     = wr_ctrl ? serial_data[11:8] : last_raw;
  assign ls_eff     = ({1'b0, ls_src} >= 5'(NUM_STEPS)) ? IW'(NUM_STEPS - 1) : ls_src[IW-1:0];
  assign settle_eff = wr_settle ? serial_data[SETTLE_WIDTH-1:0] : settle_reg;
  assign ld_ctrl    = (wr_tab && tab_idx == load_idx) ? serial_data[16 +: CTRL_WIDTH]
                                                      : ctrl_tab[load_idx];
  assign ld_dwell   = (wr_tab && tab_idx == load_idx) ? serial_data[DWELL_WIDTH-1:0]
                                                      : dwell_tab[load_idx];

  assign dwell_end = (state == ST_DWELL) && sample_strobe && (dwell_rem == DWELL_WIDTH'(1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; load marks the cycle that enters SETTLE with entry load_idx
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_idx   = '0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ctrl && serial_data[0]) begin
          state_next = ST_SETTLE;
          load       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort)                   state_next = ST_IDLE;
        else if (settle_cnt == '0)   state_next = ST_DWELL;
      end
      ST_DWELL: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (dwell_end) begin
          if (step_index < ls_eff) begin
            state_next = ST_SETTLE;
            load       = 1'b1;
            load_idx   = step_index + 1'b1;
          end else begin
            done = 1'b1;
            if (os_eff) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_SETTLE;
              load       = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    busy       = (state != ST_IDLE);
    dbg_state  = state;
    dbg_enable = enable;
  end

  // Samples pass in DWELL and in a quiet IDLE; the cycle that starts a sweep is blanked.
  assign pass_sample = (state == ST_DWELL) || (state == ST_IDLE && state_next == ST_IDLE);

  // Registers, table, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      enable       <= 1'b0;
      one_shot     <= 1'b0;
      last_raw     <= '0;
      settle_reg   <= '0;
      for (int k = 0; k < NUM_STEPS; k++) begin
        ctrl_tab[k]  <= '0;
        dwell_tab[k] <= '0;
      end
      settle_cnt   <= '0;
      dwell_rem    <= '0;
      fe_ctrl      <= '0;
      step_index   <= '0;
      sample_valid <= 1'b0;
      step_start   <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable   <= serial_data[0];
        one_shot <= serial_data[1];
        last_raw <= serial_data[11:8];
      end
      if (done && os_eff) enable <= 1'b0;
      if (wr_settle) settle_reg <= serial_data[SETTLE_WIDTH-1:0];
      if (wr_tab) begin
        ctrl_tab[tab_idx]  <= serial_data[16 +: CTRL_WIDTH];
        dwell_tab[tab_idx] <= serial_data[DWELL_WIDTH-1:0];
      end

      if (load) begin
        step_index <= load_idx;
        fe_ctrl    <= ld_ctrl;
        settle_cnt <= settle_eff;
        dwell_rem  <= (ld_dwell == '0) ? DWELL_WIDTH'(1) : ld_dwell;
      end else begin
        if (state == ST_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        if (state == ST_DWELL && sample_strobe && dwell_rem != DWELL_WIDTH'(1))
          dwell_rem <= dwell_rem - 1'b1;
      end

      sample_valid <= sample_strobe && pass_sample;
      step_start   <= (state == ST_SETTLE) && (state_next == ST_DWELL);
      sweep_done   <= done;
    end
  end

endmodule

// File: tb/tb_fe_sweep_sequencer.sv
// Bench for fe_sweep_sequencer: directed sweeps with random strobes checked cycle by cycle
// against a step-timeline model computed from the table, settle and strobe pattern.
module tb_fe_sweep_sequencer;
  localparam int NS   = 8;
  localparam int CW   = 6;
  localparam int DW   = 16;
  localparam int IW   = 3;
  localparam int EW   = CW + IW + 4;
  localparam int MAXC = 400;
  localparam logic [6:0] BASE = 7'd80;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [6:0]    serial_addr;
  logic [31:0]   serial_data;
  logic          serial_strobe, sample_strobe;
  logic [CW-1:0] fe_ctrl;
  logic [IW-1:0] step_index;
  logic          sample_valid, step_start, sweep_done, busy;
  logic [1:0]    dbg_state;
  logic          dbg_enable;

  fe_sweep_sequencer #(
    .NUM_STEPS(NS), .CTRL_WIDTH(CW), .DWELL_WIDTH(DW), .SETTLE_WIDTH(12), .BASEADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset), .serial_addr(serial_addr), .serial_data(serial_data),
    .serial_strobe(serial_strobe), .sample_strobe(sample_strobe), .fe_ctrl(fe_ctrl),
    .step_index(step_index), .sample_valid(sample_valid), .step_start(step_start),
    .sweep_done(sweep_done), .busy(busy), .dbg_state(dbg_state), .dbg_enable(dbg_enable)
  );

  int checks = 0;
  int errors = 0;

  // shadow of the programmed table and settle value
  logic [CW-1:0] m_ctrl [NS];
  int            m_dwell [NS];
  int            m_settle;

  // strobe pattern and expected per-cycle timeline
  bit            s       [MAXC];
  bit            pass    [MAXC];
  logic [CW-1:0] e_fe    [MAXC];
  logic [IW-1:0] e_idx   [MAXC];
  bit            e_valid [MAXC];
  bit            e_start [MAXC];
  bit            e_done  [MAXC];
  bit            e_busy  [MAXC];
  logic [EW-1:0] exp_q [$];

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_word();
    return 32'({fe_ctrl, step_index, sample_valid, step_start, sweep_done, busy});
  endfunction

  // driver tasks
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clock);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    sample_strobe = 1'b0;
    @(negedge clock);
    serial_strobe = 1'b0;
  endtask

  task automatic program_entry(input int k, input logic [CW-1:0] c, input int d);
    wr(BASE + 7'd2 + 7'(k), {10'd0, c, 16'(d)});
    m_ctrl[k]  = c;
    m_dwell[k] = d;
  endtask

  task automatic set_settle(input int v);
    wr(BASE + 7'd1, 32'(v));
    m_settle = v;
  endtask

  task automatic stop_sweep();
    wr(BASE, 32'd0);
  endtask

  task automatic gen_strobes(input int n, input int pct);
    for (int c = 0; c <= n; c++) s[c] = ($urandom_range(99) < pct);
  endtask

  // Model: walk the steps, placing each step's settle window and dwell window on the
  // strobe timeline; cycle 0 is the cycle carrying the enable write.
  task automatic build_plan(input int n, input int ls_raw, input bit os, input int abort_c,
                            input int w_c, input int w_idx, input logic [CW-1:0] w_ctrl,
                            input int w_dwell);
    int ls, ld, k, d0, e, need, got, ld_dwell;
    bit running;
    logic [CW-1:0] ld_ctrl;
    ls = (ls_raw >= NS) ? NS - 1 : ls_raw;
    for (int c = 0; c <= n + 1; c++) begin
      pass[c] = 0; e_fe[c] = '0; e_idx[c] = '0; e_valid[c] = 0;
      e_start[c] = 0; e_done[c] = 0; e_busy[c] = 0;
    end
    ld = 0; k = 0; running = 1;
    while (running && ld < n) begin
      if (w_c >= 0 && w_c <= ld && w_idx == k) begin
        ld_ctrl = w_ctrl; ld_dwell = w_dwell;
      end else begin
        ld_ctrl = m_ctrl[k]; ld_dwell = m_dwell[k];
      end
      for (int c = ld + 1; c <= n; c++) begin
        e_fe[c] = ld_ctrl; e_idx[c] = IW'(k); e_busy[c] = 1; pass[c] = 0;
      end
      d0 = ld + m_settle + 2;
      if (d0 > n) break;
      e_start[d0] = 1;
      need = (ld_dwell == 0) ? 1 : ld_dwell;
      got = 0; e = -1;
      for (int c = d0; c <= n; c++) begin
        if (e < 0) begin
          pass[c] = 1;
          if (s[c]) begin
            got++;
            if (got == need) e = c;
          end
        end
      end
      if (e < 0) break;
      if (k < ls) begin
        k++; ld = e;
      end else begin
        e_done[e + 1] = 1;
        if (os) begin
          for (int c = e + 1; c <= n; c++) begin e_busy[c] = 0; pass[c] = 1; end
          running = 0;
        end else begin
          k = 0; ld = e;
        end
      end
    end
    if (abort_c >= 1) begin
      for (int c = abort_c + 1; c <= n; c++) begin
        e_fe[c] = e_fe[abort_c]; e_idx[c] = e_idx[abort_c];
        e_busy[c] = 0; e_start[c] = 0; e_done[c] = 0; pass[c] = 1;
      end
    end
    for (int c = 0; c < n; c++) e_valid[c + 1] = s[c] & pass[c];
    exp_q.delete();
    for (int c = 1; c <= n; c++)
      exp_q.push_back({e_fe[c], e_idx[c], e_valid[c], e_start[c], e_done[c], e_busy[c]});
  endtask

  task automatic run_plan(input string tag, input int n, input int ls_raw, input bit os,
                          input int abort_c, input int w_c, input int w_idx,
                          input logic [CW-1:0] w_ctrl, input int w_dwell);
    logic [EW-1:0] exp;
    build_plan(n, ls_raw, os, abort_c, w_c, w_idx, w_ctrl, w_dwell);
    for (int c = 0; c <= n; c++) begin
      @(negedge clock);
      if (c > 0) begin
        exp = exp_q.pop_front();
        check($sformatf("%s_c%0d", tag, c), obs_word(), 32'(exp));
      end
      serial_strobe = 1'b0;
      sample_strobe = (c < n) ? s[c] : 1'b0;
      if (c == 0) begin
        serial_addr = BASE; serial_data = {20'd0, 4'(ls_raw), 6'd0, os, 1'b1};
        serial_strobe = 1'b1;
      end else if (c == abort_c) begin
        serial_addr = BASE; serial_data = {20'd0, 4'(ls_raw), 6'd0, os, 1'b0};
        serial_strobe = 1'b1;
      end else if (c == w_c) begin
        serial_addr = BASE + 7'd2 + 7'(w_idx); serial_data = {10'd0, w_ctrl, 16'(w_dwell)};
        serial_strobe = 1'b1;
      end
    end
    if (w_c >= 0) begin
      m_ctrl[w_idx] = w_ctrl; m_dwell[w_idx] = w_dwell;
    end
  endtask

  initial begin
    reset = 1'b1; serial_addr = '0; serial_data = '0; serial_strobe = 1'b0; sample_strobe = 1'b0;
    for (int k = 0; k < NS; k++) begin m_ctrl[k] = '0; m_dwell[k] = 0; end
    m_settle = 0;
    repeat (3) @(negedge clock);
    check("reset_outputs", obs_word(), 32'd0);
    check("reset_enable", 32'(dbg_enable), 32'd0);
    reset = 1'b0;

    // idle capture is transparent
    @(negedge clock); sample_strobe = 1'b1;
    @(negedge clock); check("idle_pass_hi", 32'(sample_valid), 32'd1); sample_strobe = 1'b0;
    @(negedge clock); check("idle_pass_lo", 32'(sample_valid), 32'd0);

    // one-shot two-step sweep
    program_entry(0, 6'h01, 4);
    program_entry(1, 6'h02, 2);
    set_settle(3);
    gen_strobes(20, 100);
    run_plan("t1", 20, 1, 1'b1, -1, -1, 0, '0, 0);
    check("t1_enable_cleared", 32'(dbg_enable), 32'd0);
    stop_sweep();

    // continuous sweep over three entries, strobe every clock
    for (int k = 0; k < 3; k++) program_entry(k, CW'($urandom_range(1, 63)), 1);
    set_settle(1);
    gen_strobes(30, 100);
    run_plan("t2", 30, 2, 1'b0, -1, -1, 0, '0, 0);
    check("t2_enable_held", 32'(dbg_enable), 32'd1);
    stop_sweep();
    check("t2_abort_idle", 32'(busy), 32'd0);

    // abort mid-dwell of step 1
    program_entry(0, 6'h05, 4);
    program_entry(1, 6'h06, 5);
    set_settle(2);
    gen_strobes(24, 100);
    for (int c = 14; c <= 24; c++) s[c] = ($urandom_range(1) == 1);
    run_plan("t3", 24, 1, 1'b0, 13, -1, 0, '0, 0);
    stop_sweep();

    // zero dwell and zero settle
    for (int k = 0; k < 4; k++) program_entry(k, CW'($urandom_range(0, 63)), 0);
    set_settle(0);
    gen_strobes(40, 60);
    run_plan("t4", 40, 3, 1'b1, -1, -1, 0, '0, 0);
    stop_sweep();

    // table rewrites during a sweep
    program_entry(0, 6'h11, 3);
    program_entry(1, 6'h12, 2);
    program_entry(2, 6'h13, 2);
    set_settle(1);
    gen_strobes(25, 100);
    run_plan("t5a", 25, 2, 1'b1, -1, 2, 1, 6'h2A, 3);
    stop_sweep();
    gen_strobes(25, 100);
    run_plan("t5b", 25, 2, 1'b1, -1, 8, 1, 6'h3F, 1);
    stop_sweep();
    gen_strobes(25, 100);
    run_plan("t5c", 25, 2, 1'b1, -1, -1, 0, '0, 0);
    stop_sweep();

    // reset in SETTLE, then restart from the cleared table
    program_entry(0, 6'h2D, 7);
    set_settle(6);
    wr(BASE, 32'h0000_0001);
    check("t6_busy_before", 32'(busy), 32'd1);
    check("t6_fe_before", 32'(fe_ctrl), 32'h2D);
    @(negedge clock); reset = 1'b1; sample_strobe = 1'b1;
    @(negedge clock);
    check("t6_reset_outputs", obs_word(), 32'd0);
    check("t6_reset_enable", 32'(dbg_enable), 32'd0);
    reset = 1'b0; sample_strobe = 1'b0;
    for (int k = 0; k < NS; k++) begin m_ctrl[k] = '0; m_dwell[k] = 0; end
    m_settle = 0;
    gen_strobes(12, 50);
    run_plan("t6", 12, 0, 1'b1, -1, -1, 0, '0, 0);
    stop_sweep();

    // randomized sweeps, with ignored writes and last_step clamping
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < NS; k++)
        program_entry(k, CW'($urandom_range(0, 63)), $urandom_range(0, 4));
      set_settle($urandom_range(0, 4));
      wr(BASE - 7'd1, $urandom);
      wr(BASE + 7'd2 + 7'(NS), $urandom);
      gen_strobes(150, $urandom_range(30, 100));
      run_plan($sformatf("rnd%0d", it), 150, $urandom_range(0, 15), 1'($urandom_range(1)),
               (it == 2) ? $urandom_range(10, 100) : -1, -1, 0, '0, 0);
      stop_sweep();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
